ctrl_pipe_regs: RTL

- Consumer end of the 24-bit decode control word: takes the word produced in ID, registers it through the ID/EX, EX/MEM and MEM/WB stage registers, and unpacks each stage's field group.
- Resolves the write-destination register from the WriteDestination code.
- Inserts bubbles on CMUX=0, flush and load-use hazard; provides the destination tags that forwarding needs.

---
 rtl/ctrl_pipe_pkg.sv | 36 +++
 rtl/ctrl_hazard_detect.sv | 16 +
 rtl/ctrl_pipe_regs.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared field positions and destination codes for the 24-bit decode control word.
// Used by ctrl_pipe_regs and ctrl_hazard_detect.
package ctrl_pipe_pkg;

    localparam int LOAD_BIT          = 0;
    localparam int MEMTOREG_BIT      = 1;
    localparam int LO_EN_BIT         = 2;
    localparam int RF_EN_BIT         = 3;
    localparam int HI_EN_BIT         = 4;
    localparam int MEM_MUX_BIT       = 5;
    localparam int MEM_SE_BIT        = 6;
    localparam int MEM_SIZE_LO       = 7;
    localparam int MEM_SIZE_HI       = 8;
    localparam int MEM_EN_BIT        = 9;
    localparam int MEM_RW_BIT        = 10;
    localparam int ALU_OP_LO         = 11;
    localparam int ALU_OP_HI         = 14;
    localparam int S0_S2_LO          = 15;
    localparam int S0_S2_HI          = 17;
    localparam int RS_ADDR_MUX_BIT   = 18;
    localparam int BASE_ADDR_MUX_BIT = 19;
    localparam int WD_LO             = 20;
    localparam int WD_HI             = 21;
    localparam int CMUX_BIT          = 22;
    localparam int JAL_ADDER_BIT     = 23;

    typedef enum logic [1:0] {
        WD_NONE = 2'd0,
        WD_RT   = 2'd1,
        WD_R31  = 2'd2,
        WD_RD   = 2'd3
    } write_dest_e;

    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/ctrl_hazard_detect.sv
// Load-use hazard compare between the instruction in EX (id_ex) and the
// source registers of the instruction currently in ID.
module ctrl_hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              load,
    input  logic              reg_we,
    input  logic [REG_AW-1:0] dest,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    output logic              stall
);

    assign stall = load & reg_we & (dest != '0) & ((dest == rs_id) | (dest == rt_id));

endmodule

// File: rtl/ctrl_pipe_regs.sv
// ID/EX, EX/MEM and MEM/WB control-word stage registers with bubble insertion.
// Define CTRL_PIPE_PERF_EN to add the bubble_count performance counter output.
module ctrl_pipe_regs
    import ctrl_pipe_pkg::*;
#(
    parameter int CW_W   = 24,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CW_W-1:0]   ctrl_word_in,
    input  logic              cmux,
    input  logic              freeze,
    input  logic              flush,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic [REG_AW-1:0] rd_id,
    output logic              load_use_stall,
    output logic [3:0]        ex_alu_op,
    output logic [2:0]        ex_s0_s2,
    output logic [REG_AW-1:0] ex_dest,
    output logic              mem_rw,
    output logic              mem_en,
    output logic              mem_se,
    output logic              mem_mux,
    output logic [1:0]        mem_size,
    output logic [REG_AW-1:0] mem_dest,
    output logic              wb_load,
    output logic              wb_memtoreg,
    output logic              wb_lo_en,
    output logic              wb_hi_en,
    output logic              wb_reg_we,
    output logic [REG_AW-1:0] wb_dest
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [31:0]       bubble_count
`endif
);

    logic [S0_S2_HI:0]   id_ex_ctrl;
    logic [REG_AW-1:0]   id_ex_dest;
    logic [MEM_RW_BIT:0] ex_mem_ctrl;
    logic [REG_AW-1:0]   ex_mem_dest;
    logic [HI_EN_BIT:0]  mem_wb_ctrl;
    logic [REG_AW-1:0]   mem_wb_dest;

    write_dest_e         wd;
    logic [REG_AW-1:0]   dest_resolved;
    logic                load_bubble;

    // These bits steer ID-stage muxes only and never enter the pipeline.
    logic unused_id_bits;
    assign unused_id_bits = ^{ctrl_word_in[JAL_ADDER_BIT], ctrl_word_in[CMUX_BIT],
                              ctrl_word_in[BASE_ADDR_MUX_BIT], ctrl_word_in[RS_ADDR_MUX_BIT]};

    always_comb begin
        wd            = write_dest_e'(ctrl_word_in[WD_HI:WD_LO]);
        dest_resolved = '0;
        case (wd)
            WD_RT:   dest_resolved = rt_id;
            WD_R31:  dest_resolved = REG_AW'(REG_RA);
            WD_RD:   dest_resolved = rd_id;
            default: dest_resolved = '0;
        endcase
    end

    ctrl_hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .load   (id_ex_ctrl[LOAD_BIT]),
        .reg_we (id_ex_ctrl[RF_EN_BIT]),
        .dest   (id_ex_dest),
        .rs_id  (rs_id),
        .rt_id  (rt_id),
        .stall  (load_use_stall)
    );

    assign load_bubble = flush | load_use_stall | ~cmux;

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_ctrl  <= '0;
            id_ex_dest  <= '0;
            ex_mem_ctrl <= '0;
            ex_mem_dest <= '0;
            mem_wb_ctrl <= '0;
            mem_wb_dest <= '0;
        end else if (!freeze) begin
            ex_mem_ctrl <= id_ex_ctrl[MEM_RW_BIT:0];
            ex_mem_dest <= id_ex_dest;
            mem_wb_ctrl <= ex_mem_ctrl[HI_EN_BIT:0];
            mem_wb_dest <= ex_mem_dest;
            if (load_bubble) begin
                id_ex_ctrl <= '0;
                id_ex_dest <= '0;
            end else begin
                id_ex_ctrl <= ctrl_word_in[S0_S2_HI:0];
                id_ex_dest <= dest_resolved;
            end
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (!freeze && load_bubble) begin
            bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

    assign ex_alu_op   = id_ex_ctrl[ALU_OP_HI:ALU_OP_LO];
    assign ex_s0_s2    = id_ex_ctrl[S0_S2_HI:S0_S2_LO];
    assign ex_dest     = id_ex_dest;

    assign mem_rw      = ex_mem_ctrl[MEM_RW_BIT];
    assign mem_en      = ex_mem_ctrl[MEM_EN_BIT];
    assign mem_size    = ex_mem_ctrl[MEM_SIZE_HI:MEM_SIZE_LO];
    assign mem_se      = ex_mem_ctrl[MEM_SE_BIT];
    assign mem_mux     = ex_mem_ctrl[MEM_MUX_BIT];
    assign mem_dest    = ex_mem_dest;

    assign wb_load     = mem_wb_ctrl[LOAD_BIT];
    assign wb_memtoreg = mem_wb_ctrl[MEMTOREG_BIT];
    assign wb_lo_en    = mem_wb_ctrl[LO_EN_BIT];
    assign wb_hi_en    = mem_wb_ctrl[HI_EN_BIT];
    assign wb_dest     = mem_wb_dest;
    // A destination of r0 means "no architectural write".
    assign wb_reg_we   = mem_wb_ctrl[RF_EN_BIT] & (mem_wb_dest != '0);

endmodule
